uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Parametrised UART receiver: next generation of the single-width, fixed-format receiver in the low-power system's UART path. Oversamples `RX_IN` with a runtime prescale and recovers frames of `DATA_W` data bits, with optional parity and one or two stop bits. Delivers each frame and its error flags through a valid/ready output register with overrun detection. Sits between the pad-side serial line and the system's register-file/command decoder.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `PRESC_W`, 6: width of the prescale input; legal oversampling 6..2^PRESC_W-1.
- `CLK  in  1`: single clock; all logic on rising edge.
- `RST  in  1`: reset; synchronous, active-high.
- `RX_IN  in  1`: asynchronous serial line, idle high.
- `Prescale  in  PRESC_W`: clocks per bit.
- `PAR_EN  in  1`: parity bit present.
- `PAR_TYP  in  1`: 0 even, 1 odd.
- `STOP2  in  1`: two stop bits expected.
- `rx_ready  in  1`: consumer accepts the held frame.
- `rx_valid  out  1`: output register holds an unconsumed frame.
- `P_DATA  out  DATA_W`: received data, LSB first on line.
- `Parity_Error  out  1`: parity mismatch for the held frame.
- `Stop_Error  out  1`: any stop bit sampled low.
- `overrun  out  1`: one-cycle pulse when a completed frame is dropped.
- `busy  out  1`: FSM not in IDLE.

## Operation
- `RX_IN` passes a 2-FF synchroniser, reset value 1; all sampling uses the synchronised line `rx_s`.
- Edge counter runs 0..Prescale-1 per bit. Samples are taken at edges m-1, m, m+1, with m = Prescale>>1. The bit value is the majority of the three samples, valid at edge m+1.
- `Prescale`, `PAR_EN`, `PAR_TYP`, `STOP2` are latched on start detection. Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, STOP2.
  - IDLE -> START: `rx_s`==0; edge counter cleared.
  - START -> IDLE if the majority value is 1 (glitch; nothing reported). Otherwise START -> DATA at bit end.
  - DATA: shifts bits LSB-first. Leaves after bit DATA_W-1, going to PARITY if `PAR_EN`, else STOP.
  - PARITY: compares the received bit with the XOR of the data, inverted when `PAR_TYP`=1.
  - STOP: majority 0 sets the stop flag. Goes to STOP2 at bit end if `STOP2`. Otherwise goes to IDLE at edge m+1 of the stop bit, not at bit end, so back-to-back frames are caught.
  - STOP2: same stop-flag rule; -> IDLE at its edge m+1.
- Frame commit happens on the transition into IDLE from STOP or STOP2:
  - If `rx_valid`=0, or `rx_valid`&&`rx_ready` in the same cycle: load `P_DATA` and both error flags, and set `rx_valid`.
  - Else: drop the new frame, keep the old one, pulse `overrun`.
- Frames with errors are still delivered; the flags accompany them.
- Handshake: transfer when `rx_valid`&&`rx_ready`. `rx_valid` clears next cycle unless a commit coincides.
- Parity width: XOR over DATA_W bits. When `PAR_EN`=0, `Parity_Error` is forced to 0.
- Reset mid-frame: FSM to IDLE, partial frame discarded.

## Timing
- Reset values: `rx_valid`=0, `P_DATA`=0, `Parity_Error`=0, `Stop_Error`=0, `overrun`=0, `busy`=0; synchroniser flops at 1.
- Start detection: 2 cycles after the falling edge on `RX_IN` (synchroniser delay). `busy` rises the cycle after `rx_s` is seen low.
- `rx_valid` rises 1 cycle after the final stop bit's edge m+1 is reached.
- `overrun` is asserted the same cycle the commit would have occurred.
- Outputs are registered; no combinational path from `RX_IN` or `rx_ready` to any output.

## Configuration
- `UART_RX_BREAK_DET_EN`.
- Defined:
  - Adds output `brk` (1 bit, reset 0).
  - A frame whose data bits, parity bit (if present) and first stop bit all sample 0 commits with `brk`=1, `P_DATA`=0 and `Stop_Error`=1.
  - After the commit, the FSM stays out of IDLE until `rx_s` has been 1 for one full bit time.
- Undefined:
  - No `brk` port.
  - Such a frame is an ordinary framing error, and the FSM returns to IDLE normally.

## Structure
- Package `uart_rx_pkg`: FSM state enum, majority-of-3 function, `DATA_W`/`PRESC_W` legality constants.
- Sub-module `uart_rx_oversampler`: synchroniser, edge counter, 3-tap majority sampler. Outputs `bit_val`, `bit_tick` (edge m+1) and `bit_end` (edge Prescale-1).
- Top level holds the FSM, shift register, parity/stop checks and the output register.

## Test plan
- DATA_W=8, Prescale=8, PAR_EN=1 even, send 0xA5 with parity 0 -> `rx_valid`, `P_DATA`=0xA5, both errors 0.
- Same setup, parity bit flipped to 1 -> `P_DATA`=0xA5, `Parity_Error`=1.
- Prescale=16, low pulse of 3 cycles on idle line -> no `rx_valid`, `busy` returns to 0 after the start bit.
- STOP2=1, send 0x3C with second stop bit 0 -> `Stop_Error`=1, data 0x3C.
- `rx_ready` held 0, two back-to-back frames 0x11 then 0x22 -> `overrun` pulses once; `P_DATA` stays 0x11; after `rx_ready`=1, `rx_valid` clears.
- `RST` asserted mid-DATA, then frame 0x5A sent -> only 0x5A is delivered; no partial frame.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// The break-detect state exists only when UART_RX_BREAK_DET_EN is defined.
package uart_rx_pkg;

    localparam int DATA_W_MIN  = 5;
    localparam int DATA_W_MAX  = 9;
    localparam int PRESC_W_MIN = 3;
    localparam int PRESC_MIN   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_STOP2
`ifdef UART_RX_BREAK_DET_EN
        , ST_BREAK
`endif
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampler.sv
// Line synchroniser, per-bit edge counter and 3-tap majority sampler.
// bit_tick marks edge m+1 (bit value valid), bit_end marks edge Prescale-1.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic               i_clr,
    output logic               o_rx_s,
    output logic               o_bit_val,
    output logic               o_bit_tick,
    output logic               o_bit_end
);

    logic               r_sync1;
    logic               r_sync2;
    logic [PRESC_W-1:0] r_edge;
    logic               r_s_lo;
    logic               r_s_mid;
    logic [PRESC_W-1:0] w_mid;

    assign w_mid = i_presc >> 1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_edge  <= '0;
            r_s_lo  <= 1'b1;
            r_s_mid <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
            if (i_clr || r_edge == i_presc - PRESC_W'(1))
                r_edge <= '0;
            else
                r_edge <= r_edge + PRESC_W'(1);
            if (r_edge == w_mid - PRESC_W'(1))
                r_s_lo <= r_sync2;
            if (r_edge == w_mid)
                r_s_mid <= r_sync2;
        end
    end

    // Third tap is the live synchronised line at edge m+1.
    assign o_rx_s     = r_sync2;
    assign o_bit_val  = maj3(r_s_lo, r_s_mid, r_sync2);
    assign o_bit_tick = (r_edge == w_mid + PRESC_W'(1));
    assign o_bit_end  = (r_edge == i_presc - PRESC_W'(1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame receiver: FSM, shift register, parity/stop checks and valid/ready output register.
// Optional break detection (brk output) is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    input  logic               rx_ready,
    output logic               rx_valid,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               Parity_Error,
    output logic               Stop_Error,
    output logic               overrun,
`ifdef UART_RX_BREAK_DET_EN
    output logic               brk,
`endif
    output logic               busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_stop2;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_par_err;
    logic               r_stop_err;
    logic               r_rx_valid;
    logic [DATA_W-1:0]  r_p_data;
    logic               r_par_err_out;
    logic               r_stop_err_out;
    logic               r_overrun;
`ifdef UART_RX_BREAK_DET_EN
    logic               r_zero;
    logic [PRESC_W-1:0] r_hi_cnt;
    logic               r_brk;
`endif

    logic w_rx_s, w_bit_val, w_bit_tick, w_bit_end;
    logic w_clr, w_commit, w_is_brk, w_stop_err_nxt;

    assign w_clr          = (r_state == ST_IDLE) && !w_rx_s;
    assign w_stop_err_nxt = r_stop_err | ~w_bit_val;

    uart_rx_oversampler #(.PRESC_W(PRESC_W)) u_os (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .i_presc    (r_presc),
        .i_clr      (w_clr),
        .o_rx_s     (w_rx_s),
        .o_bit_val  (w_bit_val),
        .o_bit_tick (w_bit_tick),
        .o_bit_end  (w_bit_end)
    );

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_commit = 1'b0;
        w_is_brk = 1'b0;
        if (w_bit_tick && ((r_state == ST_STOP && !r_stop2) || r_state == ST_STOP2))
            w_commit = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
        if (w_bit_tick && r_state == ST_STOP && r_zero && !w_bit_val) begin
            w_commit = 1'b1;
            w_is_brk = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_IDLE;
            r_presc        <= '0;
            r_par_en       <= 1'b0;
            r_par_typ      <= 1'b0;
            r_stop2        <= 1'b0;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_par_err      <= 1'b0;
            r_stop_err     <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_p_data       <= '0;
            r_par_err_out  <= 1'b0;
            r_stop_err_out <= 1'b0;
            r_overrun      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_zero         <= 1'b0;
            r_hi_cnt       <= '0;
            r_brk          <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: if (!w_rx_s) begin
                    r_state    <= ST_START;
                    r_presc    <= Prescale;
                    r_par_en   <= PAR_EN;
                    r_par_typ  <= PAR_TYP;
                    r_stop2    <= STOP2;
                    r_bit_cnt  <= '0;
                    r_par_err  <= 1'b0;
                    r_stop_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    r_zero     <= 1'b1;
`endif
                end
                ST_START: begin
                    if (w_bit_tick && w_bit_val)
                        r_state <= ST_IDLE;
                    else if (w_bit_end)
                        r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_shift   <= {w_bit_val, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef UART_RX_BREAK_DET_EN
                        r_zero    <= r_zero & ~w_bit_val;
`endif
                    end
                    if (w_bit_end && r_bit_cnt == CNT_W'(DATA_W))
                        r_state <= r_par_en ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_par_err <= w_bit_val ^ (^r_shift) ^ r_par_typ;
`ifdef UART_RX_BREAK_DET_EN
                        r_zero    <= r_zero & ~w_bit_val;
`endif
                    end
                    if (w_bit_end)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_bit_tick)
                        r_stop_err <= w_stop_err_nxt;
`ifdef UART_RX_BREAK_DET_EN
                    if (w_is_brk) begin
                        r_state  <= ST_BREAK;
                        r_hi_cnt <= '0;
                    end else
`endif
                    if (w_bit_tick && !r_stop2)
                        r_state <= ST_IDLE;
                    else if (w_bit_end && r_stop2)
                        r_state <= ST_STOP2;
                end
                ST_STOP2: if (w_bit_tick) begin
                    r_stop_err <= w_stop_err_nxt;
                    r_state    <= ST_IDLE;
                end
`ifdef UART_RX_BREAK_DET_EN
                // Hold off until the line has idled high for one full bit time.
                ST_BREAK: begin
                    if (!w_rx_s)
                        r_hi_cnt <= '0;
                    else if (r_hi_cnt == r_presc - PRESC_W'(1))
                        r_state <= ST_IDLE;
                    else
                        r_hi_cnt <= r_hi_cnt + PRESC_W'(1);
                end
`endif
                default: r_state <= ST_IDLE;
            endcase

            r_overrun <= 1'b0;
            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;
            if (w_commit) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_valid     <= 1'b1;
                    r_p_data       <= w_is_brk ? '0 : r_shift;
                    r_par_err_out  <= r_par_en && !w_is_brk && r_par_err;
                    r_stop_err_out <= w_is_brk | w_stop_err_nxt;
`ifdef UART_RX_BREAK_DET_EN
                    r_brk          <= w_is_brk;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign rx_valid     = r_rx_valid;
    assign P_DATA       = r_p_data;
    assign Parity_Error = r_par_err_out;
    assign Stop_Error   = r_stop_err_out;
    assign overrun      = r_overrun;
    assign busy         = (r_state != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign brk          = r_brk;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl (default build): directed cases plus randomized
// frames compared against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN, PAR_TYP, STOP2, rx_ready;
    logic       rx_valid;
    logic [7:0] P_DATA;
    logic       Parity_Error, Stop_Error, overrun, busy;

    int n_vec   = 0;
    int n_err   = 0;
    int ovr_cnt = 0;

    uart_rx_frame_ctrl #(.DATA_W(8), .PRESC_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .STOP2        (STOP2),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .P_DATA       (P_DATA),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (overrun === 1'b1) ovr_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic line_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    // Drives one frame; optionally scrambles the config inputs mid-frame to prove they are latched.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pbit,
                              input bit two, input bit s1, input bit s2, input bit scramble);
        logic [5:0] sv_p;
        logic       sv_pe, sv_pt, sv_s2;
        sv_p = Prescale; sv_pe = PAR_EN; sv_pt = PAR_TYP; sv_s2 = STOP2;
        line_bit(1'b0, p);
        if (scramble) begin
            Prescale = 6'($urandom_range(6, 63));
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
            STOP2    = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) line_bit(d[i], p);
        if (pe) line_bit(pbit, p);
        Prescale = sv_p; PAR_EN = sv_pe; PAR_TYP = sv_pt; STOP2 = sv_s2;
        line_bit(s1, p);
        if (two) line_bit(s2, p);
        RX_IN = 1'b1;
    endtask

    task automatic wait_valid(input int lim, input string tag);
        int k = 0;
        while (rx_valid !== 1'b1 && k < lim) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
        check({tag, "_cleared"}, 32'(rx_valid), 32'd0);
    endtask

    task automatic set_cfg(input int p, input bit pe, input bit pt, input bit two);
        Prescale = 6'(p); PAR_EN = pe; PAR_TYP = pt; STOP2 = two;
    endtask

    function automatic bit good_parity(input logic [7:0] d, input bit pt);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return bit'(ones % 2) ^ pt;
    endfunction

    initial begin
        int ovr0;
        RST = 1'b1; RX_IN = 1'b1; rx_ready = 1'b0;
        set_cfg(8, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(P_DATA), 0);
        check("rst_perr", 32'(Parity_Error), 0);
        check("rst_serr", 32'(Stop_Error), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (4) @(negedge CLK);

        // Good parity frame.
        send_frame(8'hA5, 8, 1, 0, 0, 1, 1, 0);
        wait_valid(40, "a5");
        check("a5_data", 32'(P_DATA), 32'hA5);
        check("a5_perr", 32'(Parity_Error), 0);
        check("a5_serr", 32'(Stop_Error), 0);
        handshake("a5");

        // Flipped parity bit.
        send_frame(8'hA5, 8, 1, 1, 0, 1, 1, 0);
        wait_valid(40, "a5p");
        check("a5p_data", 32'(P_DATA), 32'hA5);
        check("a5p_perr", 32'(Parity_Error), 1);
        check("a5p_serr", 32'(Stop_Error), 0);
        handshake("a5p");

        // Short glitch on idle line is rejected.
        set_cfg(16, 0, 0, 0);
        repeat (4) @(negedge CLK);
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_busy", 32'(busy), 0);

        // Second stop bit low.
        set_cfg(8, 0, 0, 1);
        send_frame(8'h3C, 8, 0, 0, 1, 1, 0, 0);
        wait_valid(40, "3c");
        check("3c_data", 32'(P_DATA), 32'h3C);
        check("3c_serr", 32'(Stop_Error), 1);
        check("3c_perr", 32'(Parity_Error), 0);
        handshake("3c");
        repeat (30) @(negedge CLK);

        // Back-to-back frames with no consumer: second one overruns.
        set_cfg(8, 0, 0, 0);
        ovr0 = ovr_cnt;
        send_frame(8'h11, 8, 0, 0, 0, 1, 1, 0);
        send_frame(8'h22, 8, 0, 0, 0, 1, 1, 0);
        repeat (24) @(negedge CLK);
        check("ovr_count", 32'(ovr_cnt - ovr0), 1);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_data", 32'(P_DATA), 32'h11);
        handshake("ovr");

        // Reset in the middle of the data bits.
        RX_IN = 1'b0;
        repeat (8 * 4) @(negedge CLK);
        RST = 1'b1; RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        repeat (40) @(negedge CLK);
        check("mid_rst_valid", 32'(rx_valid), 0);
        send_frame(8'h5A, 8, 0, 0, 0, 1, 1, 0);
        wait_valid(40, "5a");
        check("5a_data", 32'(P_DATA), 32'h5A);
        check("5a_serr", 32'(Stop_Error), 0);
        handshake("5a");

        // Randomized frames against the frame-level model.
        ovr0 = ovr_cnt;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            int         p;
            bit         pe, pt, two, pbit, s1, s2, gp, bad_stop;
            p   = $urandom_range(6, 20);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            two = 1'($urandom);
            d   = 8'($urandom);
            gp  = good_parity(d, pt);
            pbit = ($urandom_range(0, 3) == 0) ? ~gp : gp;
            s1  = ($urandom_range(0, 7) != 0);
            s2  = ($urandom_range(0, 7) != 0);
            bad_stop = !s1 || (two && !s2);
            set_cfg(p, pe, pt, two);
            send_frame(d, p, pe, pbit, two, s1, s2, 1);
            wait_valid(4 * p + 10, $sformatf("rnd%0d", n));
            check($sformatf("rnd%0d_data", n), 32'(P_DATA), 32'(d));
            check($sformatf("rnd%0d_perr", n), 32'(Parity_Error), 32'(pe && (pbit != gp)));
            check($sformatf("rnd%0d_serr", n), 32'(Stop_Error), 32'(bad_stop));
            handshake($sformatf("rnd%0d", n));
            if (bad_stop) repeat (3 * p) @(negedge CLK);
            else repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        check("rnd_no_overrun", 32'(ovr_cnt - ovr0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
